// File: rtl/seg_scan_ctrl.sv
// Purpose : multiplexed 7-segment scan; one shared hex decoder, per-digit registers, guard-blanked slots.
// Latency : write shown at the digit's next SCAN entry (1..NDIGITS*DIV cycles); an/seg registered.
// Backpr. : none; the write port is always accepted and never stalls.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   wr_en/wr_idx/wr_data digit register write; indices >= NDIGITS are dropped
//   digit_en            per-digit enable, sampled at each slot's SCAN entry
//   dec_in / dec_seg    to / from the shared external hex-to-7-segment decoder
//   an, seg             active-low digit select and segment drive (registered)
//   frame_done          one-cycle pulse after the last digit's slot ends
module seg_scan_ctrl #(
   parameter int NDIGITS   = 8,
   parameter int DIV       = 50000,
   parameter int GUARD_CYC = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [2:0]         wr_idx,
   input  logic [3:0]         wr_data,
   input  logic [NDIGITS-1:0] digit_en,
   output logic [3:0]         dec_in,
   input  logic [6:0]         dec_seg,
   output logic [NDIGITS-1:0] an,
   output logic [6:0]         seg,
   output logic               frame_done
);

   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   // Last guard count: the edge leaving it is the SCAN entry.
   localparam logic [CW-1:0] CNT_ENTRY = CW'(GUARD_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

   logic [3:0]    digit [NDIGITS];
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          wr_ok;

   assign wr_ok  = wr_en && (32'(wr_idx) < NDIGITS);

   // Shared decoder sees the currently selected digit's stored value.
   assign dec_in = digit[idx];

   // Digit storage: same-index writes on consecutive edges simply overwrite.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NDIGITS; i++) digit[i] <= 4'd0;
      end else if (wr_ok) begin
         digit[wr_idx[IW-1:0]] <= wr_data;
      end
   end

   // Slot counter, digit index and registered outputs.
   // Outputs change only at slot start (blank) and at SCAN entry (snapshot),
   // so later writes or enable changes cannot tear the digit being shown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         an         <= '1;
         seg        <= 7'h7F;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (cnt == CNT_LAST) begin
            cnt        <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            frame_done <= (idx == IDX_LAST);
            idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_ENTRY && digit_en[idx]) begin
               an  <= ~(NDIGITS'(1) << idx);
               seg <= dec_seg;
            end
         end
      end
   end

endmodule
